// File: rtl/edge_capture_reg.sv
// rtl/edge_capture_reg.sv - WIDTH-bit capture register loaded on debounced strobe edges
module edge_capture_reg #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WIDTH-1:0]     D,
    input  logic                 Strobe,
    input  logic [1:0]           Mode,
    input  logic                 Enable,
    output logic [WIDTH-1:0]     Q,
    output logic                 Capture,
    output logic [CNT_WIDTH-1:0] Count,
    output logic                 Strobe_clean
);

    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_f;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    logic                   load;
    logic                   count_ev;

    // Bring the asynchronous strobe into the clock domain through a flop chain
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Strobe};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE > 0) begin : g_debounce
            localparam int DBW = $clog2(DEBOUNCE + 1);

            logic [DBW-1:0] db_cnt;
            logic           s_f_q;

            // Filtered level only flips after DEBOUNCE consecutive mismatching cycles
            always_ff @(posedge Clock) begin
                if (!Resetn) begin
                    db_cnt <= '0;
                    s_f_q  <= 1'b0;
                end else if (s_sync == s_f_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DBW'(DEBOUNCE - 1)) begin
                    s_f_q  <= ~s_f_q;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end

            assign s_f = s_f_q;
        end else begin : g_no_debounce
            assign s_f = s_sync;
        end
    endgenerate

    assign Strobe_clean = s_f;
    assign rise         = s_f & ~prev;
    assign fall         = ~s_f & prev;

    // Select the load condition for the current mode; level mode counts only the opening edge
    always_comb begin
        load     = 1'b0;
        count_ev = 1'b0;
        case (Mode)
            MODE_RISE:  load = rise;
            MODE_FALL:  load = fall;
            MODE_BOTH:  load = rise | fall;
            MODE_LEVEL: load = s_f;
            default:    load = 1'b0;
        endcase
        load = load & Enable;
        if (Mode == MODE_LEVEL) begin
            count_ev = rise & Enable;
        end else begin
            count_ev = load;
        end
    end

    // Edge history runs every cycle so enabling or switching mode never fakes an edge
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            prev    <= 1'b0;
            Q       <= '0;
            Capture <= 1'b0;
            Count   <= '0;
        end else begin
            prev    <= s_f;
            Capture <= load;
            if (load) begin
                Q <= D;
            end
            if (count_ev && (Count != {CNT_WIDTH{1'b1}})) begin
                Count <= Count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_edge_capture_reg.sv
// tb/tb_edge_capture_reg.sv - directed vector bench for edge_capture_reg
module tb_edge_capture_reg;

    logic       clk;
    logic       resetn;
    logic [7:0] d;
    logic       strobe;
    logic [1:0] mode;
    logic       enable;

    logic [7:0] q;
    logic       capture;
    logic [7:0] count;
    logic       strobe_clean;

    logic [7:0] sat_q;
    logic       sat_capture;
    logic [2:0] sat_count;
    logic       sat_clean;

    int checks = 0;
    int errors = 0;

    edge_capture_reg dut (
        .Clock(clk), .Resetn(resetn), .D(d), .Strobe(strobe), .Mode(mode), .Enable(enable),
        .Q(q), .Capture(capture), .Count(count), .Strobe_clean(strobe_clean)
    );

    edge_capture_reg #(.CNT_WIDTH(3)) dut_sat (
        .Clock(clk), .Resetn(resetn), .D(d), .Strobe(strobe), .Mode(mode), .Enable(enable),
        .Q(sat_q), .Capture(sat_capture), .Count(sat_count), .Strobe_clean(sat_clean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       en;
        logic [7:0] d;
        logic       strobe;
        int         cycles;
        logic [7:0] q;
        int         count;
        int         caps;
        int         first;
        logic       clean;
    } vec_t;

    vec_t vecs [0:12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        chk("reset q", int'(q), 0);
        chk("reset count", int'(count), 0);
        chk("reset capture", int'(capture), 0);
        chk("reset clean", int'(strobe_clean), 0);
        chk("reset sat count", int'(sat_count), 0);
    endtask

    task automatic run_vec(input int i);
        int caps;
        int first;
        mode   = vecs[i].mode;
        enable = vecs[i].en;
        d      = vecs[i].d;
        strobe = vecs[i].strobe;
        caps   = 0;
        first  = 0;
        for (int k = 1; k <= vecs[i].cycles; k++) begin
            @(negedge clk);
            if (capture) begin
                caps++;
                if (first == 0) first = k;
            end
        end
        chk($sformatf("vec%0d q", i), int'(q), int'(vecs[i].q));
        chk($sformatf("vec%0d count", i), int'(count), vecs[i].count);
        chk($sformatf("vec%0d captures", i), caps, vecs[i].caps);
        chk($sformatf("vec%0d capture cycle", i), first, vecs[i].first);
        chk($sformatf("vec%0d clean", i), int'(strobe_clean), int'(vecs[i].clean));
    endtask

    initial begin
        int caps;
        int first;
        int clean_seen;

        //            mode   en    d      stb   cyc  q      cnt caps first clean
        vecs[0]  = '{2'd0, 1'b1, 8'hA5, 1'b1, 20, 8'hA5, 1, 1, 7, 1'b1};
        vecs[1]  = '{2'd0, 1'b1, 8'h5A, 1'b0, 20, 8'hA5, 1, 0, 0, 1'b0};
        vecs[2]  = '{2'd0, 1'b1, 8'h77, 1'b1, 12, 8'h77, 2, 1, 7, 1'b1};
        vecs[3]  = '{2'd1, 1'b1, 8'h3C, 1'b0, 12, 8'h3C, 3, 1, 7, 1'b0};
        vecs[4]  = '{2'd1, 1'b1, 8'h44, 1'b1, 12, 8'h3C, 3, 0, 0, 1'b1};
        vecs[5]  = '{2'd1, 1'b1, 8'h55, 1'b0, 12, 8'h55, 4, 1, 7, 1'b0};
        vecs[6]  = '{2'd2, 1'b1, 8'h11, 1'b1, 12, 8'h11, 5, 1, 7, 1'b1};
        vecs[7]  = '{2'd2, 1'b1, 8'h22, 1'b0, 12, 8'h22, 6, 1, 7, 1'b0};
        vecs[8]  = '{2'd0, 1'b0, 8'h99, 1'b1, 12, 8'h50, 7, 0, 0, 1'b1};
        vecs[9]  = '{2'd0, 1'b1, 8'h98, 1'b1, 12, 8'h50, 7, 0, 0, 1'b1};
        vecs[10] = '{2'd0, 1'b1, 8'h97, 1'b0, 12, 8'h50, 7, 0, 0, 1'b0};
        vecs[11] = '{2'd0, 1'b1, 8'h96, 1'b1, 12, 8'h96, 8, 1, 7, 1'b1};
        vecs[12] = '{2'd0, 1'b1, 8'h95, 1'b0, 12, 8'h96, 8, 0, 0, 1'b0};

        resetn = 1'b0;
        d      = 8'h00;
        strobe = 1'b0;
        mode   = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        do_reset();

        run_vec(0);
        run_vec(1);

        // Short glitches must never reach the filtered strobe
        mode = 2'd0;
        enable = 1'b1;
        d = 8'hEE;
        caps = 0;
        clean_seen = 0;
        for (int p = 0; p < 5; p++) begin
            strobe = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (strobe_clean) clean_seen++;
                if (capture) caps++;
            end
            strobe = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (strobe_clean) clean_seen++;
                if (capture) caps++;
            end
        end
        chk("glitch clean", clean_seen, 0);
        chk("glitch captures", caps, 0);
        chk("glitch q", int'(q), 8'hA5);
        chk("glitch count", int'(count), 1);

        for (int i = 2; i <= 7; i++) run_vec(i);

        // Level mode: Q follows D each cycle while filtered strobe is high, counted once
        mode = 2'd3;
        enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            strobe = (k <= 10);
            d = 8'h40 + 8'(k);
            @(negedge clk);
            chk($sformatf("level capture k%0d", k), int'(capture), int'(k >= 7 && k <= 16));
            if (k >= 7 && k <= 16) chk($sformatf("level q k%0d", k), int'(q), 8'h40 + k);
        end
        chk("level count", int'(count), 7);
        chk("level final q", int'(q), 8'h50);

        for (int i = 8; i <= 12; i++) run_vec(i);

        // Saturation on the narrow counter; Q must still load every edge
        do_reset();
        mode = 2'd0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'h10 + 8'(i);
            strobe = 1'b1;
            caps = 0;
            repeat (9) begin
                @(negedge clk);
                if (sat_capture) caps++;
            end
            chk($sformatf("sat q edge%0d", i), int'(sat_q), 8'h10 + i);
            chk($sformatf("sat captures edge%0d", i), caps, 1);
            strobe = 1'b0;
            repeat (9) @(negedge clk);
        end
        chk("sat count", int'(sat_count), 7);
        chk("wide count", int'(count), 10);

        // Reset lands on the same edge as a pending load; strobe stays high across release
        d = 8'hFF;
        strobe = 1'b1;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset q", int'(q), 0);
        chk("midreset count", int'(count), 0);
        chk("midreset capture", int'(capture), 0);
        chk("midreset clean", int'(strobe_clean), 0);
        resetn = 1'b1;
        d = 8'hC3;
        caps = 0;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (capture) begin
                caps++;
                if (first == 0) first = k;
            end
        end
        chk("release capture cycle", first, 7);
        chk("release captures", caps, 1);
        chk("release q", int'(q), 8'hC3);
        chk("release count", int'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
